qspi_mem_responder: RTL

// - QPI-mode (4-bit, all phases quad) SPI memory responder: the device end of the QSPI RAM/flash link

---
 rtl/qspi_mem_responder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_mem_responder.sv
// QPI (all-quad) SPI memory responder bridging a tinyQV-style QSPI link onto a byte-wide memory port.
// Optional flash continuous-read mode is built when QSPI_RESP_CONT_READ_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a fresh CS assertion
// CMD    | receiving the two command nibbles
// ADDR   | shifting in the address, MSB nibble first
// DUMMY  | counting dummy cycles while the first byte is prefetched
// RDATA  | driving read nibbles on falling edges
// WDATA  | collecting write nibbles, one memory write per byte
// IGNORE | unsupported command, silent until CS releases
module qspi_mem_responder #(
   parameter int ADDR_BITS     = 24,
   parameter int DUMMY_NIBBLES = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 spi_clk,
   input  logic                 spi_cs_n,
   input  logic [3:0]           spi_data_in,
   output logic [3:0]           spi_data_out,
   output logic [3:0]           spi_data_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 mem_wr,
   output logic                 mem_rd,
   input  logic [7:0]           mem_rdata,
   output logic                 busy
);
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);
`ifdef QSPI_RESP_CONT_READ_EN
   localparam logic [7:0] DUMMY_MODE = 8'(DUMMY_NIBBLES - 2);
`endif

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
   } state_t;

   logic                 clk_s1_q, clk_s2_q, clk_s3_q;
   logic                 cs_s1_q, cs_s2_q;
   logic [3:0]           din_s1_q, din_s2_q;
   state_t               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [3:0]           sh_q, sh_d;
   logic [3:0]           lo_q, lo_d;
   logic [7:0]           pf_q, pf_d;
   logic                 half_q, half_d;
   logic                 wr_q, wr_d;
   logic                 armed_q, armed_d;
   logic                 cont_q, cont_d;
   logic                 rd_vld_q;
   logic [3:0]           dout_q, dout_d;
   logic                 oe_q, oe_d;
   logic                 mem_wr_q, mem_wr_d;
   logic                 mem_rd_q, mem_rd_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 rise, fall;
   logic [7:0]           cmd_byte;

   assign rise     = clk_s2_q & ~clk_s3_q;
   assign fall     = ~clk_s2_q & clk_s3_q;
   assign cmd_byte = {sh_q, din_s2_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      sh_d     = sh_q;
      lo_d     = lo_q;
      pf_d     = pf_q;
      half_d   = half_q;
      wr_d     = wr_q;
      armed_d  = armed_q | cs_s2_q;
      cont_d   = cont_q;
      dout_d   = dout_q;
      oe_d     = oe_q;
      mem_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      wdata_d  = wdata_q;
      if (rd_vld_q) pf_d = mem_rdata;
      // the write address stays put for the strobe cycle, then advances
      if (mem_wr_q) addr_d = addr_q + ADDR_BITS'(1);
      if (cs_s2_q) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         sh_d    = '0;
         cnt_d   = '0;
         half_d  = 1'b0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // armed_q stays low after reset until CS has been seen high
               if (armed_q) begin
                  half_d = 1'b0;
                  if (cont_q) begin
                     state_d = ST_ADDR;
                     wr_d    = 1'b0;
                     cnt_d   = ADDR_LAST;
                  end else begin
                     state_d = ST_CMD;
                     cnt_d   = 8'd1;
                  end
               end
            end
            ST_CMD: if (rise) begin
               sh_d = din_s2_q;
               if (cnt_q == 8'd0) begin
                  cnt_d = ADDR_LAST;
                  if (cmd_byte == 8'hEB) begin
                     state_d = ST_ADDR;
                     wr_d    = 1'b0;
                  end else if (cmd_byte == 8'h38 || cmd_byte == 8'h02) begin
                     state_d = ST_ADDR;
                     wr_d    = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_ADDR: if (rise) begin
               addr_d = {addr_q[ADDR_BITS-5:0], din_s2_q};
               if (cnt_q == 8'd0) begin
                  if (wr_q) begin
                     state_d = ST_WDATA;
                  end else begin
                     state_d  = ST_DUMMY;
                     mem_rd_d = 1'b1;
                     cnt_d    = DUMMY_LAST;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_DUMMY: if (rise) begin
`ifdef QSPI_RESP_CONT_READ_EN
               if (cnt_q == DUMMY_LAST) sh_d = din_s2_q;
               if (cnt_q == DUMMY_MODE) cont_d = (sh_q[1:0] == 2'b10);
`endif
               if (cnt_q == 8'd0) begin
                  state_d = ST_RDATA;
                  half_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_RDATA: if (fall) begin
               if (!half_q) begin
                  dout_d   = pf_q[7:4];
                  lo_d     = pf_q[3:0];
                  oe_d     = 1'b1;
                  addr_d   = addr_q + ADDR_BITS'(1);
                  mem_rd_d = 1'b1;
                  half_d   = 1'b1;
               end else begin
                  dout_d = lo_q;
                  half_d = 1'b0;
               end
            end
            ST_WDATA: if (rise) begin
               if (!half_q) begin
                  sh_d   = din_s2_q;
                  half_d = 1'b1;
               end else begin
                  mem_wr_d = 1'b1;
                  wdata_d  = {sh_q, din_s2_q};
                  half_d   = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q <= 1'b0;
         clk_s2_q <= 1'b0;
         clk_s3_q <= 1'b0;
         cs_s1_q  <= 1'b0;
         cs_s2_q  <= 1'b0;
         din_s1_q <= '0;
         din_s2_q <= '0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         sh_q     <= '0;
         lo_q     <= '0;
         pf_q     <= '0;
         half_q   <= 1'b0;
         wr_q     <= 1'b0;
         armed_q  <= 1'b0;
         cont_q   <= 1'b0;
         rd_vld_q <= 1'b0;
         dout_q   <= '0;
         oe_q     <= 1'b0;
         mem_wr_q <= 1'b0;
         mem_rd_q <= 1'b0;
         wdata_q  <= '0;
      end else begin
         clk_s1_q <= spi_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         cs_s1_q  <= spi_cs_n;
         cs_s2_q  <= cs_s1_q;
         din_s1_q <= spi_data_in;
         din_s2_q <= din_s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         sh_q     <= sh_d;
         lo_q     <= lo_d;
         pf_q     <= pf_d;
         half_q   <= half_d;
         wr_q     <= wr_d;
         armed_q  <= armed_d;
         cont_q   <= cont_d;
         rd_vld_q <= mem_rd_q;
         dout_q   <= dout_d;
         oe_q     <= oe_d;
         mem_wr_q <= mem_wr_d;
         mem_rd_q <= mem_rd_d;
         wdata_q  <= wdata_d;
      end
   end

   assign spi_data_out = dout_q;
   assign spi_data_oe  = {4{oe_q}};
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_wr       = mem_wr_q;
   assign mem_rd       = mem_rd_q;
   assign busy         = (state_q != ST_IDLE);
endmodule
